// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide beside the ALU: one radix-2 step per cycle, 33-cycle fixed latency.
// Result held until next completion; new start only taken in IDLE (done cycle included), flush aborts.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      MulDivOp,
   input  logic [XLEN-1:0] Operand1,
   input  logic [XLEN-1:0] Operand2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] MulDivOut
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     count;
   logic [2:0]        op;
   logic              neg1, neg2, div0;
   logic [XLEN-1:0]   op1_raw, mag1, mag2, rem;
   logic [2*XLEN-1:0] acc;

   logic              accept, sgn1, sgn2, neg1_in, neg2_in;
   logic [XLEN-1:0]   mag1_in, mag2_in;
   logic [XLEN:0]     mul_sum, rem_sh, rem_dif;
   logic              rem_ge;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo_fix, rem_fix, result;

   assign accept = (state == IDLE) && start && !flush;
   assign busy   = (state != IDLE);

   always_comb begin
      sgn1 = 1'b0;
      sgn2 = 1'b0;
      case (MulDivOp)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sgn1 = 1'b1;
            sgn2 = 1'b1;
         end
         3'b010:  sgn1 = 1'b1;
         default: ;
      endcase
   end

   assign neg1_in = sgn1 & Operand1[XLEN-1];
   assign neg2_in = sgn2 & Operand2[XLEN-1];
   assign mag1_in = neg1_in ? -Operand1 : Operand1;
   assign mag2_in = neg2_in ? -Operand2 : Operand2;

   // Multiply: acc low half starts as the multiplier and shifts out as product bits shift in.
   assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag1} : {(XLEN+1){1'b0}});

   // Divide: mag1 doubles as dividend/quotient shift register; rem_sh may exceed XLEN bits.
   assign rem_sh  = {rem, mag1[XLEN-1]};
   assign rem_dif = rem_sh - {1'b0, mag2};
   assign rem_ge  = rem_sh[XLEN] | ~rem_dif[XLEN];

   assign prod    = (neg1 ^ neg2) ? -acc : acc;
   assign quo_fix = (neg1 ^ neg2) ? -mag1 : mag1;
   assign rem_fix = neg1 ? -rem : rem;

   always_comb begin
      result = prod[XLEN-1:0];
      case (op)
         3'b000:                 result = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         result = div0 ? {XLEN{1'b1}} : quo_fix;
         default:                result = div0 ? op1_raw : rem_fix;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (count == CW'(XLEN-1)) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         op        <= '0;
         neg1      <= 1'b0;
         neg2      <= 1'b0;
         div0      <= 1'b0;
         op1_raw   <= '0;
         mag1      <= '0;
         mag2      <= '0;
         rem       <= '0;
         acc       <= '0;
         done      <= 1'b0;
         MulDivOut <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            op      <= MulDivOp;
            neg1    <= neg1_in;
            neg2    <= neg2_in;
            div0    <= (Operand2 == '0);
            op1_raw <= Operand1;
            mag1    <= mag1_in;
            mag2    <= mag2_in;
            rem     <= '0;
            acc     <= {{XLEN{1'b0}}, mag2_in};
            count   <= '0;
         end else if (state == CALC) begin
            count <= count + 1'b1;
            if (op[2]) begin
               mag1 <= {mag1[XLEN-2:0], rem_ge};
               rem  <= rem_ge ? rem_dif[XLEN-1:0] : rem_sh[XLEN-1:0];
            end else begin
               acc <= {mul_sum, acc[XLEN-1:1]};
            end
         end else if (state == FIN && !flush) begin
            MulDivOut <= result;
            done      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed results, latency, busy window, flush and reset.
module tb_ex_muldiv_unit;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  MulDivOp;
   logic [31:0] Operand1, Operand2;
   logic        busy, done;
   logic [31:0] MulDivOut;

   int checks   = 0;
   int failures = 0;
   int lat, bcnt, n;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .MulDivOp  (MulDivOp),
      .Operand1  (Operand1),
      .Operand2  (Operand2),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .MulDivOut (MulDivOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns 1 time unit after the accept edge with operands scrambled.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start    = 1'b1;
      MulDivOp = op;
      Operand1 = a;
      Operand2 = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      MulDivOp = ~op;
      Operand1 = ~a;
      Operand2 = b ^ 32'h5A5A_A5A5;
   endtask

   // l = clock edges from accept to done; bc = busy-high cycles before done. Bounded.
   task automatic wait_done(output int l, output int bc);
      l  = 0;
      bc = 0;
      while (l <= 60) begin
         @(negedge clk);
         if (done) break;
         bc += int'(busy);
         @(posedge clk);
         l++;
      end
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      int l, bc;
      @(negedge clk);
      issue(op, a, b);
      wait_done(l, bc);
      check({tag, "_lat"}, l, 33);
      check({tag, "_res"}, MulDivOut, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0;
      MulDivOp = 3'b000; Operand1 = '0; Operand2 = '0;
      #12;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_out", MulDivOut, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // MUL with full timing checks
      @(negedge clk);
      issue(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD);
      wait_done(lat, bcnt);
      check("mul_lat", lat, 33);
      check("mul_busy_cycles", bcnt, 33);
      check("mul_busy_in_done", {31'b0, busy}, 32'd0);
      check("mul_res", MulDivOut, 32'hFFFF_FFEB);
      @(negedge clk);
      check("mul_done_pulse", {31'b0, done}, 32'd0);
      check("mul_out_held", MulDivOut, 32'hFFFF_FFEB);

      run("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("div",    OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
      run("rem",    OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
      run("divu",   OP_DIVU,   32'd100,       32'd7,         32'h0000_000E);
      run("remu",   OP_REMU,   32'd100,       32'd7,         32'h0000_0002);
      run("div0",   OP_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF);
      run("rem0",   OP_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9);
      run("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

      // Ignored start, then flush mid-operation
      run("mul5", OP_MUL, 32'd5, 32'd5, 32'd25);
      @(negedge clk);
      issue(OP_DIVU, 32'd9, 32'd3);
      repeat (3) @(negedge clk);
      start = 1'b1; MulDivOp = OP_MUL; Operand1 = 32'd7; Operand2 = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_out", MulDivOut, 32'd25);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         n += int'(done);
      end
      check("flush_no_done", n, 0);
      check("flush_out_held", MulDivOut, 32'd25);

      // Ignored start with operation running to completion
      @(negedge clk);
      issue(OP_DIVU, 32'd9, 32'd3);
      repeat (3) @(negedge clk);
      start = 1'b1; MulDivOp = OP_MUL; Operand1 = 32'd7; Operand2 = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat, bcnt);
      check("ign_start_res", MulDivOut, 32'd3);

      // Flush wins over start in IDLE
      @(negedge clk);
      start = 1'b1; flush = 1'b1; MulDivOp = OP_MUL; Operand1 = 32'd2; Operand2 = 32'd2;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("idle_flush_busy", {31'b0, busy}, 32'd0);

      // Back-to-back: start issued in the done cycle
      @(negedge clk);
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_done(lat, bcnt);
      check("b2b_first", MulDivOut, 32'd14);
      issue(OP_MUL, 32'd6, 32'd7);
      wait_done(lat, bcnt);
      check("b2b_lat", lat, 33);
      check("b2b_res", MulDivOut, 32'd42);

      // Asynchronous reset during CALC
      @(negedge clk);
      issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_done", {31'b0, done}, 32'd0);
      check("arst_out", MulDivOut, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run("post_rst", OP_DIVU, 32'd10, 32'd3, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
